// File: rtl/asoc_frame_tx_if.sv
// Handshake and serial-output bundle for asoc_frame_tx.
// The master side issues frame requests and supplies samples; the slave side is the transmitter.
interface asoc_frame_tx_if;
    logic        frame_start;
    logic [7:0]  chan_id;
    logic        s_valid;
    logic [11:0] s_data;
    logic        s_ready;
    logic        sdo;
    logic        sfr;
    logic        busy;
    logic        underrun;

    modport master (
        output frame_start, chan_id, s_valid, s_data,
        input  s_ready, sdo, sfr, busy, underrun
    );

    modport slave (
        input  frame_start, chan_id, s_valid, s_data,
        output s_ready, sdo, sfr, busy, underrun
    );
endinterface

// File: rtl/asoc_frame_tx.sv
// Serial frame transmitter: SYNC, HDR {chan_id, NSAMP}, NSAMP 12-bit samples, optional CRC, GAP.
// Define ASOC_TX_CRC_EN to append a CRC-16-CCITT trailer computed over HDR and DATA.
module asoc_frame_tx #(
    parameter int unsigned NSAMP     = 16,
    parameter int unsigned GAP_CYC   = 4,
    parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
    input  logic           clk,
    input  logic           rst_n,
    asoc_frame_tx_if.slave tx
);

    // Absolute frame-bit indices at which each field ends.
    localparam logic [15:0] SYNC_LAST = 16'd15;
    localparam logic [15:0] HDR_LAST  = 16'd31;
    localparam logic [15:0] DATA_LAST = 16'(32 + 12 * NSAMP - 1);
`ifdef ASOC_TX_CRC_EN
    localparam logic [15:0] CRC_LAST  = 16'(48 + 12 * NSAMP - 1);
`endif
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);
    localparam logic [7:0]  NSAMP_B   = 8'(NSAMP);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HDR,
        ST_DATA,
`ifdef ASOC_TX_CRC_EN
        ST_CRC,
`endif
        ST_GAP
    } state_t;

    state_t      state_reg,   state_next;
    logic [15:0] bit_cnt_reg, bit_cnt_next;
    logic [3:0]  sub_cnt_reg, sub_cnt_next;
    logic [15:0] sr_reg,      sr_next;
    logic [7:0]  chan_reg,    chan_next;
    logic        underrun_reg, underrun_next;
    logic        s_ready_int;
    logic        accept;
    logic        in_frame;
    logic [15:0] sample_word;

`ifdef ASOC_TX_CRC_EN
    logic [15:0] crc_reg, crc_next;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`endif

    // A missing sample is zero-filled rather than retried, so frame length never changes.
    assign sample_word = {(tx.s_valid ? tx.s_data : 12'h000), 4'h0};

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        sub_cnt_next  = sub_cnt_reg;
        sr_next       = sr_reg;
        chan_next     = chan_reg;
        underrun_next = 1'b0;
        s_ready_int   = 1'b0;
        accept        = 1'b0;
`ifdef ASOC_TX_CRC_EN
        crc_next      = crc_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                accept = tx.frame_start;
            end

            ST_SYNC: begin
                bit_cnt_next = bit_cnt_reg + 16'd1;
                sr_next      = {sr_reg[14:0], 1'b0};
                if (bit_cnt_reg == SYNC_LAST) begin
                    state_next = ST_HDR;
                    sr_next    = {chan_reg, NSAMP_B};
                end
            end

            ST_HDR: begin
                bit_cnt_next = bit_cnt_reg + 16'd1;
                sr_next      = {sr_reg[14:0], 1'b0};
`ifdef ASOC_TX_CRC_EN
                crc_next     = crc_step(crc_reg, sr_reg[15]);
`endif
                if (bit_cnt_reg == HDR_LAST) begin
                    state_next    = ST_DATA;
                    s_ready_int   = 1'b1;
                    sr_next       = sample_word;
                    underrun_next = ~tx.s_valid;
                    sub_cnt_next  = 4'd0;
                end
            end

            ST_DATA: begin
                bit_cnt_next = bit_cnt_reg + 16'd1;
                sub_cnt_next = sub_cnt_reg + 4'd1;
                sr_next      = {sr_reg[14:0], 1'b0};
`ifdef ASOC_TX_CRC_EN
                crc_next     = crc_step(crc_reg, sr_reg[15]);
`endif
                if (bit_cnt_reg == DATA_LAST) begin
`ifdef ASOC_TX_CRC_EN
                    state_next = ST_CRC;
                    sr_next    = crc_step(crc_reg, sr_reg[15]);
`else
                    state_next   = ST_GAP;
                    bit_cnt_next = 16'd0;
                    sr_next      = 16'd0;
`endif
                end else if (sub_cnt_reg == 4'd11) begin
                    s_ready_int   = 1'b1;
                    sr_next       = sample_word;
                    underrun_next = ~tx.s_valid;
                    sub_cnt_next  = 4'd0;
                end
            end

`ifdef ASOC_TX_CRC_EN
            ST_CRC: begin
                bit_cnt_next = bit_cnt_reg + 16'd1;
                sr_next      = {sr_reg[14:0], 1'b0};
                if (bit_cnt_reg == CRC_LAST) begin
                    state_next   = ST_GAP;
                    bit_cnt_next = 16'd0;
                    sr_next      = 16'd0;
                end
            end
`endif

            ST_GAP: begin
                bit_cnt_next = bit_cnt_reg + 16'd1;
                if (bit_cnt_reg == GAP_LAST) begin
                    // The closing GAP edge doubles as the IDLE sampling point so a held
                    // frame_start yields exactly GAP_CYC dead cycles between frames.
                    state_next = ST_IDLE;
                    accept     = tx.frame_start;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_next   = ST_SYNC;
            chan_next    = tx.chan_id;
            sr_next      = SYNC_WORD;
            bit_cnt_next = 16'd0;
            sub_cnt_next = 4'd0;
`ifdef ASOC_TX_CRC_EN
            crc_next     = 16'hFFFF;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= 16'd0;
            sub_cnt_reg  <= 4'd0;
            sr_reg       <= 16'd0;
            chan_reg     <= 8'd0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            sub_cnt_reg  <= sub_cnt_next;
            sr_reg       <= sr_next;
            chan_reg     <= chan_next;
            underrun_reg <= underrun_next;
        end
    end

`ifdef ASOC_TX_CRC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg <= 16'd0;
        end else begin
            crc_reg <= crc_next;
        end
    end
`endif

    // Outputs decode directly from reset-cleared state so an async reset silences them at once.
    always_comb begin
        in_frame = 1'b0;
        case (state_reg)
            ST_SYNC, ST_HDR, ST_DATA: in_frame = 1'b1;
`ifdef ASOC_TX_CRC_EN
            ST_CRC:                   in_frame = 1'b1;
`endif
            default:                  in_frame = 1'b0;
        endcase
    end

    assign tx.sfr      = in_frame;
    assign tx.sdo      = in_frame & sr_reg[15];
    assign tx.busy     = (state_reg != ST_IDLE);
    assign tx.s_ready  = s_ready_int;
    assign tx.underrun = underrun_reg;

endmodule

// File: tb/tb_asoc_frame_tx.sv
// Directed bench for asoc_frame_tx: basic frame, underrun, back-to-back, mid-frame reset.
// Frame length and CRC trailer expectations follow ASOC_TX_CRC_EN.
module tb_asoc_frame_tx;

    localparam int NS  = 16;
    localparam int GAP = 4;
`ifdef ASOC_TX_CRC_EN
    localparam int FLEN = 48 + 12 * NS;
`else
    localparam int FLEN = 32 + 12 * NS;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    asoc_frame_tx_if ifc();

    asoc_frame_tx #(
        .NSAMP     (NS),
        .GAP_CYC   (GAP),
        .SYNC_WORD (16'hEB90)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx    (ifc.slave)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    logic cap [0:1023];
    int   cap_len, ur_cnt, ur_pos, rdy_cnt, lead;
    logic first_busy, timed_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] get_bits(input int off, input int w);
        logic [15:0] v;
        v = 16'd0;
        for (int i = 0; i < w; i++) v = {v[14:0], cap[off + i]};
        return v;
    endfunction

    // Source presents 1,2,3,... and only advances on a real handshake.
    function automatic logic [11:0] exp_samp(input int j, input int miss);
        if (miss < 0 || j < miss) return 12'(j + 1);
        if (j == miss) return 12'h000;
        return 12'(j);
    endfunction

    function automatic logic [15:0] ref_crc(input int nbits);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int i = 16; i < 16 + nbits; i++) begin
            fb = c[15] ^ cap[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Called with frame_start already driven; returns at the first sfr=0 cycle after the frame.
    task automatic capture_frame(input int miss, input int pa, input int pb, input bit hold);
        int src_ptr;
        int budget;
        src_ptr = 0; budget = 0;
        cap_len = 0; ur_cnt = 0; ur_pos = -1; rdy_cnt = 0; lead = 0;
        first_busy = 1'b0; timed_out = 1'b0;
        while (1) begin
            @(negedge clk);
            budget++;
            if (budget > 2000) begin
                timed_out = 1'b1;
                break;
            end
            if (ifc.underrun) begin
                ur_cnt++;
                ur_pos = cap_len;
            end
            if (ifc.sfr) begin
                if (cap_len == 0) first_busy = ifc.busy;
                if (cap_len < 1024) cap[cap_len] = ifc.sdo;
                cap_len++;
            end else if (cap_len > 0) begin
                break;
            end else begin
                lead++;
            end
            if (ifc.s_ready) begin
                ifc.s_valid = (rdy_cnt != miss);
                ifc.s_data  = 12'(src_ptr + 1);
                if (ifc.s_valid) src_ptr++;
                rdy_cnt++;
            end else begin
                ifc.s_valid = 1'b0;
                ifc.s_data  = 12'hFFF;
            end
            if (!hold && cap_len > 0) ifc.frame_start = (cap_len == pa) || (cap_len == pb);
        end
    endtask

    task automatic check_frame(input string nm, input logic [7:0] chan, input int miss);
        check({nm, "_timeout"}, 32'(timed_out), 32'd0);
        check({nm, "_lead"}, 32'(lead), 32'd0);
        check({nm, "_first_busy"}, 32'(first_busy), 32'd1);
        check({nm, "_sync"}, 32'(get_bits(0, 16)), 32'hEB90);
        check({nm, "_hdr"}, 32'(get_bits(16, 16)), {16'd0, chan, 8'(NS)});
        for (int j = 0; j < NS; j++)
            check($sformatf("%s_samp%0d", nm, j), 32'(get_bits(32 + 12 * j, 12)), 32'(exp_samp(j, miss)));
        check({nm, "_len"}, 32'(cap_len), 32'(FLEN));
        check({nm, "_ready_cnt"}, 32'(rdy_cnt), 32'(NS));
`ifdef ASOC_TX_CRC_EN
        check({nm, "_crc"}, 32'(get_bits(32 + 12 * NS, 16)), 32'(ref_crc(16 + 12 * NS)));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   zeros;
        logic loc [0:127];

        ifc.frame_start = 1'b1;
        ifc.chan_id     = 8'h05;
        ifc.s_valid     = 1'b0;
        ifc.s_data      = 12'h000;

        // Reset held: frame_start must not start anything.
        repeat (2) @(negedge clk);
        check("rst_sdo", 32'(ifc.sdo), 32'd0);
        check("rst_sfr", 32'(ifc.sfr), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_s_ready", 32'(ifc.s_ready), 32'd0);
        check("rst_underrun", 32'(ifc.underrun), 32'd0);

        // Basic frame accepted on the first edge after release, with ignored pulses in SYNC and DATA.
        rst_n = 1'b1;
        capture_frame(-1, 3, 120, 1'b0);
        check_frame("basic", 8'h05, -1);
        check("basic_underrun_cnt", 32'(ur_cnt), 32'd0);

        // GAP: busy high, sfr low for GAP cycles; a pulse in GAP is ignored.
        check("gap0", {30'd0, ifc.busy, ifc.sfr}, 32'b10);
        for (int g = 1; g < GAP; g++) begin
            @(negedge clk);
            check($sformatf("gap%0d", g), {30'd0, ifc.busy, ifc.sfr}, 32'b10);
            ifc.frame_start = (g == 1);
        end
        @(negedge clk);
        check("idle_after_gap", {30'd0, ifc.busy, ifc.sfr}, 32'b00);
        @(negedge clk);
        check("gap_pulse_ignored", {30'd0, ifc.busy, ifc.sfr}, 32'b00);

        // Underrun on sample 3 only.
        ifc.chan_id     = 8'hA7;
        ifc.frame_start = 1'b1;
        capture_frame(3, -1, -1, 1'b0);
        check_frame("urun", 8'hA7, 3);
        check("urun_cnt", 32'(ur_cnt), 32'd1);
        check("urun_pos", 32'(ur_pos), 32'(32 + 12 * 3));
        repeat (GAP + 2) @(negedge clk);

        // Back-to-back with frame_start held high.
        ifc.chan_id     = 8'h5A;
        ifc.frame_start = 1'b1;
        capture_frame(-1, -1, -1, 1'b1);
        check_frame("b2b", 8'h5A, -1);
        ifc.chan_id = 8'h66;
        zeros = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc.sfr) break;
            zeros++;
        end
        check("b2b_gap_cycles", 32'(zeros), 32'(GAP));
        ifc.frame_start = 1'b0;
        ifc.s_valid     = 1'b1;
        ifc.s_data      = 12'h123;

        // Second frame: record to DATA sample 5, bit 3 (sdo=1), then assert reset.
        loc[0] = ifc.sdo;
        for (int i = 1; i <= 95; i++) begin
            @(negedge clk);
            loc[i] = ifc.sdo;
        end
        begin
            logic [15:0] h;
            h = 16'd0;
            for (int i = 16; i < 32; i++) h = {h[14:0], loc[i]};
            check("b2b2_hdr", 32'(h), {16'd0, 8'h66, 8'(NS)});
        end
        check("pre_rst_sdo", 32'(ifc.sdo), 32'd1);
        check("pre_rst_sfr", 32'(ifc.sfr), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_outs",
              {27'd0, ifc.sdo, ifc.sfr, ifc.busy, ifc.s_ready, ifc.underrun}, 32'd0);
        @(negedge clk);
        check("midrst_hold",
              {27'd0, ifc.sdo, ifc.sfr, ifc.busy, ifc.s_ready, ifc.underrun}, 32'd0);

        // Release with a new request: a complete fresh frame.
        ifc.s_valid     = 1'b0;
        ifc.chan_id     = 8'h3C;
        ifc.frame_start = 1'b1;
        rst_n           = 1'b1;
        capture_frame(-1, 2, 100, 1'b0);
        check_frame("post_rst", 8'h3C, -1);

        repeat (GAP + 2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/asoc_frame_tx.md
ASOC_FRAME_TX -- requirements
Module: asoc_frame_tx

Interface
REQ-001 Parameter NSAMP, default 16: samples per frame, legal range 1..255.
REQ-002 Parameter GAP_CYC, default 4: idle cycles after each frame, legal range 1..255.
REQ-003 Parameter SYNC_WORD, default 16'hEB90: frame sync pattern.
REQ-004 clk  input  1  system clock; one serial bit per cycle.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 frame_start  input  1  request to send one frame; sampled only in IDLE.
REQ-007 chan_id  input  8  channel ID, latched on an accepted frame_start.
REQ-008 s_valid  input  1  sample available.
REQ-009 s_data  input  12  sample value.
REQ-010 s_ready  output  1  sample accept strobe; transfer when s_valid and s_ready are both high.
REQ-011 sdo  output  1  serial data, MSB-first.
REQ-012 sfr  output  1  high on every cycle that carries a frame bit.
REQ-013 busy  output  1  high from an accepted frame_start to the end of GAP.
REQ-014 underrun  output  1  one-cycle pulse when a sample is zero-filled.

Function
REQ-015 States SHALL be IDLE, SYNC, HDR, DATA, CRC and GAP; the CRC state exists only per REQ-033.
REQ-016 In IDLE, frame_start=1 at edge N SHALL latch chan_id and enter SYNC; the first SYNC_WORD bit SHALL appear on sdo in the cycle after edge N, with sfr=1 and busy=1.
REQ-017 SYNC SHALL shift 16 bits of SYNC_WORD, then enter HDR.
REQ-018 HDR SHALL shift 16 bits, {chan_id, NSAMP[7:0]}, then enter DATA.
REQ-019 DATA SHALL shift NSAMP 12-bit samples in acceptance order, then enter CRC if present, else GAP.
REQ-020 s_ready SHALL be high for exactly one cycle per sample: the last bit cycle of HDR for sample 0, and the last bit cycle of sample k for sample k+1.
REQ-021 s_ready SHALL be low in every other cycle.
REQ-022 At an s_ready cycle with s_valid=1, s_data SHALL load into the shift register and its MSB SHALL appear on sdo in the next cycle.
REQ-023 At an s_ready cycle with s_valid=0, the block SHALL transmit 12'h000 for that sample and pulse underrun in that sample's first bit cycle.
REQ-024 After an underrun, the frame length SHALL be unchanged and the block SHALL NOT retry the missed sample.
REQ-025 GAP SHALL hold sdo=0, sfr=0 and busy=1 for GAP_CYC cycles, then enter IDLE.
REQ-026 frame_start SHALL be ignored while busy=1, including in the GAP state.
REQ-027 In IDLE, frame_start=1 SHALL start back-to-back frames separated by exactly GAP_CYC idle cycles.
REQ-028 Frame length without CRC SHALL be 32+12*NSAMP bits, with a 16-bit bit counter and no wrap within a frame.

Reset
REQ-029 While rst_n=0, the block SHALL force state=IDLE, sdo=0, sfr=0, s_ready=0, busy=0, underrun=0, and clear all shift registers, counters and CRC.
REQ-030 An rst_n assertion mid-frame SHALL abort the frame immediately with no resume; the first frame after release SHALL be complete.
REQ-031 Reset release SHALL be synchronous to clk.
REQ-032 frame_start in the first cycle after release SHALL be accepted.

Configuration
REQ-033 With macro ASOC_TX_CRC_EN defined, the block SHALL append a CRC state after DATA that shifts 16 CRC bits MSB-first.
REQ-034 The appended CRC SHALL be CRC-16-CCITT: polynomial 0x1021, init 0xFFFF, no reflection, no final XOR, computed over HDR and DATA bits only, excluding SYNC.
REQ-035 With ASOC_TX_CRC_EN defined, frame length SHALL be 48+12*NSAMP bits.
REQ-036 Without ASOC_TX_CRC_EN, the block SHALL have no CRC state or CRC logic and DATA SHALL go directly to GAP.

Verification
REQ-037 Basic frame: NSAMP=16, chan_id=8'h05, s_valid held high, samples 0x001..0x010 -> sdo = EB90, 0510, then 16 samples MSB-first; sfr high for 224 cycles.
REQ-038 Underrun: s_valid=0 at the sample-3 s_ready cycle only -> sample 3 = 12'h000, one underrun pulse, and the following samples are the next accepted values.
REQ-039 CRC: ASOC_TX_CRC_EN, NSAMP=1, chan_id=8'h00, sample 12'hABC -> 16-bit trailer equals reference-model CRC; sfr high for 60 cycles.
REQ-040 Busy/back-to-back: frame_start held high, GAP_CYC=4 -> exactly 4 sfr=0 cycles between frames; pulses during SYNC/DATA/GAP are ignored.
REQ-041 Reset mid-frame: rst_n low during DATA sample 5 -> all outputs zero within the same cycle; after release, a fresh frame starts with SYNC.
REQ-042 Loopback: sdo/sfr fed into the ASOC readout receiver -> all 16 samples and chan_id recovered bit-exact.
